// File: rtl/coeff_pkg.sv
// rtl/coeff_pkg.sv - shared constants and FSM encoding for the coefficient store
`timescale 1ns/1ps
package coeff_pkg;

  localparam int COEFF_DATA_W = 16;

  // Bank select values, shared with the circular-buffer reader
  localparam logic OP_MU  = 1'b0;
  localparam logic OP_VAR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_MU  = 2'd1,
    ST_LOAD_VAR = 2'd2,
    ST_DONE     = 2'd3
  } coeff_state_e;

endpackage

// File: rtl/coeff_buffer_writer_if.sv
// rtl/coeff_buffer_writer_if.sv - coefficient load stream (valid/ready/data/last)
`timescale 1ns/1ps
interface coeff_buffer_writer_if
  import coeff_pkg::*;
#(
  parameter int DATA_W = COEFF_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/coeff_bank_ram.sv
// rtl/coeff_bank_ram.sv - one coefficient bank, 1 write port, registered read-before-write read port
`timescale 1ns/1ps
module coeff_bank_ram #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; sees the pre-write value on a same-address collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/coeff_buffer_writer.sv
// rtl/coeff_buffer_writer.sv - fills mu/var coefficient banks from a stream; optional COEFF_LOAD_CHECKSUM_EN
`timescale 1ns/1ps
module coeff_buffer_writer
  import coeff_pkg::*;
#(
  parameter  int DATA_W = COEFF_DATA_W,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef COEFF_LOAD_CHECKSUM_EN
  output logic [DATA_W-1:0] mu_sum,
  output logic [DATA_W-1:0] var_sum,
`endif
  input  logic              start,
  coeff_buffer_writer_if.slave s,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              rd_en,
  input  logic              rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  coeff_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              in_ready_q;
  logic              err_q;
  logic              rd_sel_q;
  logic              hs, start_ok, last_word, frame_err;
  logic              mu_we, var_we;
  logic [DATA_W-1:0] mu_rd, var_rd;

  assign s.in_ready = in_ready_q;
  assign hs         = s.in_valid & in_ready_q;
  assign start_ok   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign last_word  = &ptr_q;
  // in_last only belongs on the final var word; anything else is a framing error
  assign frame_err  = ((state_q == ST_LOAD_MU)  & s.in_last) |
                      ((state_q == ST_LOAD_VAR) & (s.in_last ^ last_word));
  assign err        = err_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: advance bank on the last word, abort to DONE on a framing error
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_LOAD_MU;
      ST_LOAD_MU:  if (hs) begin
                     if (frame_err)      state_d = ST_DONE;
                     else if (last_word) state_d = ST_LOAD_VAR;
                   end
      ST_LOAD_VAR: if (hs && (frame_err || last_word)) state_d = ST_DONE;
      ST_DONE:     if (start) state_d = ST_LOAD_MU;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs and bank write strobes
  always_comb begin
    busy   = (state_q == ST_LOAD_MU) | (state_q == ST_LOAD_VAR);
    done   = (state_q == ST_DONE);
    mu_we  = hs & (state_q == ST_LOAD_MU);
    var_we = hs & (state_q == ST_LOAD_VAR);
  end

  // Write pointer, sticky error and ready; ready follows the upcoming state so it has no gap between banks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= (state_d == ST_LOAD_MU) | (state_d == ST_LOAD_VAR);
      if (start_ok) begin
        ptr_q <= '0;
        err_q <= 1'b0;
      end else if (hs) begin
        ptr_q <= ptr_q + 1'b1;
        if (frame_err) err_q <= 1'b1;
      end
    end
  end

`ifdef COEFF_LOAD_CHECKSUM_EN
  // Wrapping per-bank sums of accepted words since the last start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mu_sum  <= '0;
      var_sum <= '0;
    end else if (start_ok) begin
      mu_sum  <= '0;
      var_sum <= '0;
    end else begin
      if (mu_we)  mu_sum  <= mu_sum + s.in_data;
      if (var_we) var_sum <= var_sum + s.in_data;
    end
  end
`endif

  // Bank select follows the read request so rd_data holds while rd_en is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_sel_q <= OP_MU;
    else if (rd_en) rd_sel_q <= rd_sel;
  end

  assign rd_data = (rd_sel_q == OP_MU) ? mu_rd : var_rd;

  coeff_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mu_bank (
    .clk(clk), .rst(rst),
    .we(mu_we), .waddr(ptr_q), .wdata(s.in_data),
    .re(rd_en), .raddr(rd_addr), .rdata(mu_rd)
  );

  coeff_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_var_bank (
    .clk(clk), .rst(rst),
    .we(var_we), .waddr(ptr_q), .wdata(s.in_data),
    .re(rd_en), .raddr(rd_addr), .rdata(var_rd)
  );

endmodule

// File: tb/tb_coeff_buffer_writer.sv
// tb/tb_coeff_buffer_writer.sv - directed self-checking bench for coeff_buffer_writer
`timescale 1ns/1ps
module tb_coeff_buffer_writer;
  import coeff_pkg::*;

  localparam int DW = 16;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;
  logic rd_en = 1'b0;
  logic rd_sel = 1'b0;
  logic [9:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
`ifdef COEFF_LOAD_CHECKSUM_EN
  logic [DW-1:0] mu_sum, var_sum;
`endif

  int n_checks = 0;
  int n_fail = 0;

  coeff_buffer_writer_if #(.DATA_W(DW)) bus ();

  coeff_buffer_writer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
`ifdef COEFF_LOAD_CHECKSUM_EN
    .mu_sum(mu_sum), .var_sum(var_sum),
`endif
    .start(start), .s(bus), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic rd(input logic sel, input logic [9:0] addr, output logic [DW-1:0] q);
    rd_en = 1'b1; rd_sel = sel; rd_addr = addr;
    step();
    q = rd_data;
    rd_en = 1'b0;
  endtask

  // Drives words base+idx; returns accepted count and done as seen just before the final edge
  task automatic send_stream(input int n, input logic [DW-1:0] base, input int last_at,
                             input bit throttle, output int accepted, output logic pre_done);
    int idx = 0;
    int cyc = 0;
    bit phase = 1'b1;
    bit hs;
    pre_done = 1'bx;
    while (idx < n && cyc < 2 * n + 20) begin
      bus.in_valid = throttle ? phase : 1'b1;
      bus.in_data  = base + DW'(idx);
      bus.in_last  = (idx == last_at);
      hs = bus.in_valid && bus.in_ready;
      if (hs && idx == n - 1) pre_done = done;
      step();
      if (hs) idx++;
      phase = ~phase;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    accepted = idx;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if ({busy, done, err, bus.in_ready} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, bus.in_ready}); end
    n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_full_load();
    int acc; logic pd; logic [DW-1:0] q;
    pulse_start();
    n_checks++; if ({busy, bus.in_ready, done} !== 3'b110) begin n_fail++; $display("FAIL full_start_flags: got %b expected 110", {busy, bus.in_ready, done}); end
    send_stream(2048, 16'h0000, 2047, 1'b0, acc, pd);
    n_checks++; if (acc !== 2048) begin n_fail++; $display("FAIL full_count: got %0d expected 2048", acc); end
    n_checks++; if ({done, err, busy, bus.in_ready} !== 4'b1000) begin n_fail++; $display("FAIL full_end_flags: got %b expected 1000", {done, err, busy, bus.in_ready}); end
    rd(OP_MU, 10'd5, q);
    n_checks++; if (q !== 16'h0005) begin n_fail++; $display("FAIL full_mu5: got %h expected 0005", q); end
    rd(OP_VAR, 10'd5, q);
    n_checks++; if (q !== 16'h0405) begin n_fail++; $display("FAIL full_var5: got %h expected 0405", q); end
    rd_sel = OP_MU; rd_addr = 10'd9;
    step();
    n_checks++; if (rd_data !== 16'h0405) begin n_fail++; $display("FAIL full_rd_hold: got %h expected 0405", rd_data); end
    rd(OP_MU, 10'd1023, q);
    n_checks++; if (q !== 16'h03FF) begin n_fail++; $display("FAIL full_mu_top: got %h expected 03ff", q); end
    rd(OP_VAR, 10'd1023, q);
    n_checks++; if (q !== 16'h07FF) begin n_fail++; $display("FAIL full_var_top: got %h expected 07ff", q); end
`ifdef COEFF_LOAD_CHECKSUM_EN
    n_checks++; if ({mu_sum, var_sum} !== 32'hFE00_FE00) begin n_fail++; $display("FAIL full_sums: got %h expected fe00fe00", {mu_sum, var_sum}); end
`endif
  endtask

  task automatic test_collision();
    int acc; logic pd; logic [DW-1:0] q;
    pulse_start();
    send_stream(7, 16'h0000, -1, 1'b0, acc, pd);
    bus.in_valid = 1'b1; bus.in_data = 16'hBEEF; bus.in_last = 1'b0;
    rd_en = 1'b1; rd_sel = OP_MU; rd_addr = 10'd7;
    step();
    bus.in_valid = 1'b0; rd_en = 1'b0;
    n_checks++; if (rd_data !== 16'h0007) begin n_fail++; $display("FAIL collide_old: got %h expected 0007", rd_data); end
    rd(OP_MU, 10'd7, q);
    n_checks++; if (q !== 16'hBEEF) begin n_fail++; $display("FAIL collide_new: got %h expected beef", q); end
    // start while busy must not rewind the pointer: the next word lands at mu[8]
    pulse_start();
    send_stream(1, 16'hCAFE, -1, 1'b0, acc, pd);
    rd(OP_MU, 10'd8, q);
    n_checks++; if (q !== 16'hCAFE) begin n_fail++; $display("FAIL busy_start_ignored: got %h expected cafe", q); end
    rd(OP_MU, 10'd0, q);
    n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL busy_start_mu0: got %h expected 0000", q); end
    do_reset();
  endtask

  task automatic test_throttled();
    int acc; logic pd; logic [DW-1:0] q;
    pulse_start();
    send_stream(2048, 16'h1000, 2047, 1'b1, acc, pd);
    n_checks++; if (acc !== 2048) begin n_fail++; $display("FAIL thr_count: got %0d expected 2048", acc); end
    n_checks++; if (pd !== 1'b0) begin n_fail++; $display("FAIL thr_done_early: got %b expected 0", pd); end
    n_checks++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL thr_done: got %b expected 10", {done, err}); end
    rd(OP_MU, 10'd0, q);
    n_checks++; if (q !== 16'h1000) begin n_fail++; $display("FAIL thr_mu0: got %h expected 1000", q); end
    rd(OP_MU, 10'd1023, q);
    n_checks++; if (q !== 16'h13FF) begin n_fail++; $display("FAIL thr_mu_top: got %h expected 13ff", q); end
    rd(OP_VAR, 10'd0, q);
    n_checks++; if (q !== 16'h1400) begin n_fail++; $display("FAIL thr_var0: got %h expected 1400", q); end
    rd(OP_VAR, 10'd513, q);
    n_checks++; if (q !== 16'h1601) begin n_fail++; $display("FAIL thr_var513: got %h expected 1601", q); end
  endtask

  task automatic test_early_last();
    int acc; logic pd; logic [DW-1:0] q;
    pulse_start();
    send_stream(11, 16'h2000, 10, 1'b0, acc, pd);
    n_checks++; if ({err, done, bus.in_ready, busy} !== 4'b1100) begin n_fail++; $display("FAIL early_flags: got %b expected 1100", {err, done, bus.in_ready, busy}); end
    bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
    step(); step();
    bus.in_valid = 1'b0;
    rd(OP_MU, 10'd10, q);
    n_checks++; if (q !== 16'h200A) begin n_fail++; $display("FAIL early_mu10: got %h expected 200a", q); end
    rd(OP_MU, 10'd11, q);
    n_checks++; if (q !== 16'h100B) begin n_fail++; $display("FAIL early_mu11: got %h expected 100b", q); end
    rd(OP_VAR, 10'd0, q);
    n_checks++; if (q !== 16'h1400) begin n_fail++; $display("FAIL early_var0: got %h expected 1400", q); end
`ifdef COEFF_LOAD_CHECKSUM_EN
    n_checks++; if ({mu_sum, var_sum} !== 32'h6037_0000) begin n_fail++; $display("FAIL early_sums: got %h expected 60370000", {mu_sum, var_sum}); end
`endif
  endtask

  task automatic test_missing_last();
    int acc; logic pd; logic [DW-1:0] q;
    pulse_start();
    n_checks++; if ({err, done} !== 2'b00) begin n_fail++; $display("FAIL miss_start_clear: got %b expected 00", {err, done}); end
    send_stream(2048, 16'h3000, -1, 1'b0, acc, pd);
    n_checks++; if (pd !== 1'b0) begin n_fail++; $display("FAIL miss_done_early: got %b expected 0", pd); end
    n_checks++; if ({err, done} !== 2'b11) begin n_fail++; $display("FAIL miss_flags: got %b expected 11", {err, done}); end
    rd(OP_VAR, 10'd1023, q);
    n_checks++; if (q !== 16'h37FF) begin n_fail++; $display("FAIL miss_var_top: got %h expected 37ff", q); end
  endtask

  task automatic test_async_reset();
    int acc; logic pd; logic [DW-1:0] q;
    pulse_start();
    send_stream(300, 16'h4000, -1, 1'b0, acc, pd);
    rd(OP_MU, 10'd1, q);
    n_checks++; if ({busy, q} !== {1'b1, 16'h4001}) begin n_fail++; $display("FAIL ar_preload: got %h expected 14001", {busy, q}); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({busy, bus.in_ready, done, err} !== 4'b0000) begin n_fail++; $display("FAIL ar_flags: got %b expected 0000", {busy, bus.in_ready, done, err}); end
    n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL ar_rd_data: got %h expected 0000", rd_data); end
    step();
    rst = 1'b1;
    step();
    rd(OP_MU, 10'd0, q);
    n_checks++; if (q !== 16'h4000) begin n_fail++; $display("FAIL ar_keep_mu0: got %h expected 4000", q); end
    rd(OP_MU, 10'd299, q);
    n_checks++; if (q !== 16'h412B) begin n_fail++; $display("FAIL ar_keep_mu299: got %h expected 412b", q); end
    rd(OP_MU, 10'd300, q);
    n_checks++; if (q !== 16'h312C) begin n_fail++; $display("FAIL ar_keep_mu300: got %h expected 312c", q); end
    pulse_start();
    send_stream(1, 16'h5555, -1, 1'b0, acc, pd);
    rd(OP_MU, 10'd0, q);
    n_checks++; if (q !== 16'h5555) begin n_fail++; $display("FAIL ar_reload_mu0: got %h expected 5555", q); end
    rd(OP_MU, 10'd1, q);
    n_checks++; if (q !== 16'h4001) begin n_fail++; $display("FAIL ar_reload_mu1: got %h expected 4001", q); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    test_reset();
    test_full_load();
    test_collision();
    test_throttled();
    test_early_last();
    test_missing_last();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
